// File: rtl/dct_out_demux_if.sv
// dct_out_demux_if: row-beat input and steered output bundle for the DCT output demux
interface dct_out_demux_if #(
  parameter int DW    = 16,
  parameter int LANES = 32
);
  logic                i_start;
  logic [1:0]          i_size;
  logic                i_valid;
  logic [DW*LANES-1:0] i_data;
  logic                o_busy;
  logic                o_tr_valid;
  logic [DW*LANES-1:0] o_tr_data;
  logic                o_out_valid;
  logic [DW*LANES-1:0] o_out_data;
  logic                o_out_last;
  logic                o_done;
  logic                o_err;
  modport master (
    output i_start, i_size, i_valid, i_data,
    input  o_busy, o_tr_valid, o_tr_data, o_out_valid, o_out_data, o_out_last, o_done, o_err
  );
  modport slave (
    input  i_start, i_size, i_valid, i_data,
    output o_busy, o_tr_valid, o_tr_data, o_out_valid, o_out_data, o_out_last, o_done, o_err
  );
endinterface

// File: rtl/dct_out_demux.sv
// dct_out_demux: steers 1D DCT row beats to the transpose buffer (pass 1) or output path (pass 2)
module dct_out_demux #(
  parameter int DW    = 16,
  parameter int LANES = 32
) (
  input logic             clk,
  input logic             rst_n,
  dct_out_demux_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;
  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          size_q, size_d;
  logic                tr_valid_q, tr_valid_d;
  logic                out_valid_q, out_valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [DW*LANES-1:0] tr_data_q, tr_data_d;
  logic [DW*LANES-1:0] out_data_q, out_data_d;
  logic [5:0]          rows_m1;
  logic                last_row;
  // Six bits so that 32 rows does not wrap before the minus one.
  assign rows_m1  = (6'd4 << size_q) - 6'd1;
  assign last_row = {1'b0, cnt_q} == rows_m1;
  // State, counter, latched size and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      tr_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      tr_data_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      tr_valid_q  <= tr_valid_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      tr_data_q   <= tr_data_d;
      out_data_q  <= out_data_d;
    end
  end
  // Pass sequencing and beat steering; data buses hold unless their own beat arrives.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    tr_valid_d  = 1'b0;
    out_valid_d = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    tr_data_d   = tr_data_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          size_d  = bus.i_size;
          state_d = PASS1;
          cnt_d   = bus.i_valid ? 5'd1 : 5'd0;
          if (bus.i_valid) begin
            tr_valid_d = 1'b1;
            tr_data_d  = bus.i_data;
          end
        end else begin
          err_d = bus.i_valid;
        end
      end
      PASS1: begin
        if (bus.i_valid) begin
          tr_valid_d = 1'b1;
          tr_data_d  = bus.i_data;
          cnt_d      = last_row ? 5'd0 : cnt_q + 5'd1;
          state_d    = last_row ? PASS2 : PASS1;
        end
      end
      PASS2: begin
        if (bus.i_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.i_data;
          last_d      = last_row;
          cnt_d       = last_row ? 5'd0 : cnt_q + 5'd1;
          state_d     = last_row ? IDLE : PASS2;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.o_busy      = state_q != IDLE;
  assign bus.o_tr_valid  = tr_valid_q;
  assign bus.o_tr_data   = tr_data_q;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_out_data  = out_data_q;
  assign bus.o_out_last  = last_q;
  assign bus.o_done      = last_q;
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_dct_out_demux.sv
// tb_dct_out_demux: directed stimulus with a per-TU beat-index model checked every cycle
module tb_dct_out_demux;
  localparam int W = 512;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  dct_out_demux_if #(.DW(16), .LANES(32)) bus ();
  dct_out_demux #(.DW(16), .LANES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Model: a TU is 2N beats; beat b goes to transpose if b < N, else output; last at b == 2N-1.
  logic         m_act;
  int           m_b, m_n;
  logic         e_tr_v, e_out_v, e_last, e_err;
  logic [W-1:0] e_tr_d, e_out_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_b <= 0; m_n <= 0;
      e_tr_v <= 1'b0; e_out_v <= 1'b0; e_last <= 1'b0; e_err <= 1'b0;
      e_tr_d <= '0; e_out_d <= '0;
    end else begin
      e_tr_v <= 1'b0; e_out_v <= 1'b0; e_last <= 1'b0; e_err <= 1'b0;
      if (!m_act) begin
        if (bus.i_start) begin
          m_act <= 1'b1;
          m_n   <= 4 << bus.i_size;
          m_b   <= bus.i_valid ? 1 : 0;
          if (bus.i_valid) begin
            e_tr_v <= 1'b1;
            e_tr_d <= bus.i_data;
          end
        end else if (bus.i_valid) begin
          e_err <= 1'b1;
        end
      end else if (bus.i_valid) begin
        if (m_b < m_n) begin
          e_tr_v <= 1'b1;
          e_tr_d <= bus.i_data;
        end else begin
          e_out_v <= 1'b1;
          e_out_d <= bus.i_data;
        end
        if (m_b == 2 * m_n - 1) begin
          e_last <= 1'b1;
          m_act  <= 1'b0;
          m_b    <= 0;
        end else begin
          m_b <= m_b + 1;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask
  // Observed event tallies used by the literal checks.
  int n_tr = 0, n_out = 0, n_done = 0, n_err = 0;
  logic [W-1:0] last_out_d = '0;
  always @(negedge clk) begin
    chk("busy", W'(bus.o_busy), W'(m_act));
    chk("tr_valid", W'(bus.o_tr_valid), W'(e_tr_v));
    chk("tr_data", bus.o_tr_data, e_tr_d);
    chk("out_valid", W'(bus.o_out_valid), W'(e_out_v));
    chk("out_data", bus.o_out_data, e_out_d);
    chk("out_last", W'(bus.o_out_last), W'(e_last));
    chk("done", W'(bus.o_done), W'(e_last));
    chk("err", W'(bus.o_err), W'(e_err));
    chk("exclusive", W'(bus.o_tr_valid & bus.o_out_valid), W'(0));
    n_tr   += int'(bus.o_tr_valid);
    n_out  += int'(bus.o_out_valid);
    n_done += int'(bus.o_done);
    n_err  += int'(bus.o_err);
    if (bus.o_done) last_out_d = bus.o_out_data;
  end
  function automatic logic [W-1:0] mk(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 31; k++) r[16*k +: 16] = 16'(v + k);
    r[511:496] = 16'hFFFF;
    return r;
  endfunction
  task automatic drive(input logic s, input logic [1:0] sz, input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    bus.i_start = s;
    bus.i_size  = sz;
    bus.i_valid = v;
    bus.i_data  = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, '0);
  endtask
  int bt, bo, bd, be;
  task automatic mark();
    bt = n_tr; bo = n_out; bd = n_done; be = n_err;
  endtask
  initial begin
    bus.i_start = 1'b0; bus.i_size = 2'd0; bus.i_valid = 1'b0; bus.i_data = '0;
    idle(2);
    @(negedge clk);
    chk("reset_tr_data", bus.o_tr_data, '0);
    chk("reset_busy", W'(bus.o_busy), W'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    // 4x4 TU, start with first beat, lane0 = 1..8
    mark();
    drive(1'b1, 2'd0, 1'b1, mk(1));
    for (int i = 2; i <= 8; i++) drive(1'b0, 2'd0, 1'b1, mk(i));
    idle(3);
    chk("t1_tr_count", W'(n_tr - bt), W'(4));
    chk("t1_out_count", W'(n_out - bo), W'(4));
    chk("t1_done_count", W'(n_done - bd), W'(1));
    chk("t1_last_lane0", W'(last_out_d[15:0]), W'(16'd8));
    // 32x32 TU with a 3-cycle gap after beat 20
    mark();
    drive(1'b1, 2'd3, 1'b0, '0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 2'd0, 1'b1, mk(100 + i));
      if (i == 19) idle(3);
    end
    idle(3);
    chk("t2_tr_count", W'(n_tr - bt), W'(32));
    chk("t2_out_count", W'(n_out - bo), W'(32));
    chk("t2_last_lane0", W'(last_out_d[15:0]), W'(16'd163));
    chk("t2_last_lane31", W'(last_out_d[511:496]), W'(16'hFFFF));
    // 8x8 TU, start and first beat together
    mark();
    drive(1'b1, 2'd1, 1'b1, mk(300));
    for (int i = 1; i < 16; i++) drive(1'b0, 2'd0, 1'b1, mk(300 + i));
    idle(2);
    chk("t3_tr_count", W'(n_tr - bt), W'(8));
    chk("t3_out_count", W'(n_out - bo), W'(8));
    chk("t3_last_lane0", W'(last_out_d[15:0]), W'(16'd315));
    // Stray beat in IDLE, then start on the final PASS2 beat is ignored
    mark();
    drive(1'b0, 2'd0, 1'b1, mk(500));
    idle(2);
    chk("t4_err_count", W'(n_err - be), W'(1));
    chk("t4_no_beats", W'((n_tr - bt) + (n_out - bo)), W'(0));
    drive(1'b1, 2'd0, 1'b0, '0);
    for (int i = 0; i < 7; i++) drive(1'b0, 2'd0, 1'b1, mk(600 + i));
    drive(1'b1, 2'd3, 1'b1, mk(607));
    idle(3);
    chk("t4_busy_after", W'(bus.o_busy), W'(0));
    chk("t4_done_count", W'(n_done - bd), W'(1));
    // Reset in the middle of a 16x16 TU, then a clean 8x8 TU
    drive(1'b1, 2'd2, 1'b0, '0);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'd0, 1'b1, mk(700 + i));
    mark();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    #2;
    chk("t5_rst_tr_data", bus.o_tr_data, '0);
    chk("t5_rst_busy", W'(bus.o_busy), W'(0));
    chk("t5_rst_tr_valid", W'(bus.o_tr_valid), W'(0));
    idle(2);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(1'b0, 2'd0, 1'b1, mk(800 + i));
    idle(3);
    chk("t5_done_count", W'(n_done - bd), W'(1));
    chk("t5_out_count", W'(n_out - bo), W'(8));
    chk("t5_last_lane0", W'(last_out_d[15:0]), W'(16'd815));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dct_out_demux.md
Name: dct_out_demux

Overview:
- Splitter on the output side of the shared 1D DCT datapath; it is the counterpart of the org/transpose input merge in front of that datapath.
- Takes 32-lane row beats from the 1D transform and steers them by pass:
  - first-pass rows go to the transpose buffer;
  - second-pass rows go to the quantiser/output path.
- Tracks rows per pass from the latched TU size and sequences the two passes with a small FSM, one registered stage deep.

Parameters:
DW, 16, bit width of one signed coefficient lane
LANES, 32, lanes per row beat

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse, begin a new TU (sampled only in IDLE)
i_size  input  2  TU size at i_start: 0=4x4, 1=8x8, 2=16x16, 3=32x32
i_valid  input  1  row beat valid from 1D transform
i_data  input  DW*LANES  row beat, lane k at bits [DW*k+DW-1 : DW*k], signed
o_busy  output  1  high whenever state != IDLE (combinational from state)
o_tr_valid  output  1  row beat valid toward transpose buffer
o_tr_data  output  DW*LANES  row beat toward transpose buffer
o_out_valid  output  1  row beat valid toward output path
o_out_data  output  DW*LANES  row beat toward output path
o_out_last  output  1  high with final second-pass row of the TU
o_done  output  1  one-cycle pulse, coincident with o_out_last
o_err  output  1  one-cycle pulse, i_valid received in IDLE (beat dropped)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, row counter=0, latched size=0.
  - All valid, last, done and err outputs are 0; both data buses are 0.
- Rows per pass N = 4 << size_latched (4, 8, 16, 32); one beat = one row for every size. Unused lanes pass through unchanged.
- Row counter: 5 bits, counts 0..N-1, resets to 0 at each pass boundary.
- FSM:
  - IDLE:
    - i_start=1: latch i_size, clear counter, go to PASS1.
    - i_valid=1 without i_start: beat dropped, o_err pulses next cycle.
  - PASS1:
    - Each i_valid beat is registered onto o_tr_data/o_tr_valid next cycle; counter increments.
    - Beat with counter==N-1: counter goes to 0, state goes to PASS2.
  - PASS2:
    - Each i_valid beat is registered onto o_out_data/o_out_valid next cycle; counter increments.
    - Beat with counter==N-1: o_out_last and o_done assert with that output beat; state goes to IDLE.
- i_start is ignored outside IDLE, including on the final PASS2 beat. The next TU's i_start must arrive no earlier than the cycle after state reaches IDLE (o_busy low).
- i_start and i_valid together in IDLE: start accepted, and that beat is PASS1 row 0 for the newly latched size; counter becomes 1.
- Latency: exactly 1 cycle from i_valid to o_tr_valid or o_out_valid.
- Output exclusivity: o_tr_valid and o_out_valid are never high in the same cycle.
- Data buses load only on their own valid beat and otherwise hold their last value. Valid, last, done and err are single-cycle pulses.
- No back-pressure: the transpose buffer and the output path accept every beat.
- i_valid gaps inside a pass are allowed; the counter holds during gaps.
- Reset mid-TU: returns to IDLE immediately, and the partial TU is discarded with no o_done.

Test Plan:
- 4x4 TU: i_start with size=0 plus 8 consecutive beats with lane0 = 1..8 -> o_tr_valid on rows 1-4 (cycles 1-4), o_out_valid on rows 5-8; o_out_last and o_done on row 8 only; o_busy low from the cycle after the last beat.
- 32x32 TU with a gap: 64 beats, 3 idle cycles inserted after beat 20 -> 32 tr beats then 32 out beats; no beat lost or duplicated; lane31 = 0xFFFF (-1) passes unchanged.
- Start with same-cycle valid: i_start plus i_valid together, size=1 -> first beat appears on o_tr_valid; PASS2 begins after exactly 7 more beats.
- Stray input: i_valid in IDLE with no start -> o_err pulses once, no tr/out valid. Then i_start on the final PASS2 beat of a later TU -> ignored, state ends in IDLE.
- Reset mid-TU: rst_n low after 10 beats of a 16x16 TU -> all outputs 0, state IDLE. A new 8x8 TU afterwards completes normally with 8+8 beats.
